// File: rtl/pc_loop_monitor.sv
// pc_loop_monitor: run-control monitor that detects endless loops in the retired PC stream and enforces a retirement budget
// Ports:
//   clk, rst (async, active high), clr (sync restart)
//   valid/pc/instr : retirement stream
//   rd_idx -> hist_rd_data : PC history read port, 0 = most recent
//   cycle_cnt : valid retirements counted while running
//   loop_found/loop_period/loop_pc/loop_instr : sticky loop report
//   timeout : sticky budget exhaustion, done = loop_found | timeout
module pc_loop_monitor #(
   parameter int PC_W          = 32,
   parameter int HIST_DEPTH    = 8,
   parameter int STABLE_CYCLES = 16,
   parameter int MAX_CYCLES    = 400,
   parameter int CNT_W         = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          valid,
   input  logic [PC_W-1:0]               pc,
   input  logic [PC_W-1:0]               instr,
   input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
   output logic [PC_W-1:0]               hist_rd_data,
   output logic [CNT_W-1:0]              cycle_cnt,
   output logic                          loop_found,
   output logic [$clog2(HIST_DEPTH):0]   loop_period,
   output logic [PC_W-1:0]               loop_pc,
   output logic [PC_W-1:0]               loop_instr,
   output logic                          timeout,
   output logic                          done
);
   localparam int PER_W = $clog2(HIST_DEPTH) + 1;
   localparam int MC_W  = $clog2(STABLE_CYCLES + 1);
   typedef enum logic [1:0] {S_RUN, S_LOOP, S_TIMEOUT} state_t;
   state_t            r_state, w_next;
   logic [PC_W-1:0]   r_hist [HIST_DEPTH];
   logic [MC_W-1:0]   r_mc [HIST_DEPTH];
   logic [PER_W-1:0]  r_hist_cnt;
   logic [CNT_W-1:0]  r_cnt;
   logic [PER_W-1:0]  r_period;
   logic [PC_W-1:0]   r_loop_pc, r_loop_instr;
   logic [HIST_DEPTH-1:0] w_m, w_hit;
   logic [PER_W-1:0]  w_period;
   logic              w_adv, w_to;
   // Descending scan so the last assignment leaves the smallest matching period.
   always_comb begin
      w_m      = '0;
      w_hit    = '0;
      w_period = '0;
      for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
         w_m[i]   = (r_hist_cnt > PER_W'(i)) && (pc == r_hist[i]);
         w_hit[i] = w_m[i] && (32'(r_mc[i]) + 32'd1 >= 32'(STABLE_CYCLES));
         if (w_hit[i]) w_period = PER_W'(i + 1);
      end
   end
   assign w_adv = (r_state == S_RUN) && valid;
   assign w_to  = (r_cnt + CNT_W'(1)) == CNT_W'(MAX_CYCLES);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= clr ? S_RUN : w_next;
   end
   // Loop detection has priority over a coincident timeout.
   always_comb begin
      w_next = !w_adv ? r_state : |w_hit ? S_LOOP : w_to ? S_TIMEOUT : S_RUN;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         for (int i = 0; i < HIST_DEPTH; i++) begin
            r_hist[i] <= '0;
            r_mc[i]   <= '0;
         end
         r_hist_cnt   <= '0;
         r_cnt        <= '0;
         r_period     <= '0;
         r_loop_pc    <= '0;
         r_loop_instr <= '0;
      end else if (w_adv) begin
         r_hist[0] <= pc;
         for (int i = HIST_DEPTH - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
         for (int i = 0; i < HIST_DEPTH; i++)
            r_mc[i] <= !w_m[i] ? '0 :
                       (32'(r_mc[i]) >= 32'(STABLE_CYCLES)) ? r_mc[i] : r_mc[i] + MC_W'(1);
         r_hist_cnt <= r_hist_cnt + PER_W'(r_hist_cnt != PER_W'(HIST_DEPTH));
         r_cnt      <= r_cnt + CNT_W'(1);
         if (|w_hit) begin
            r_period     <= w_period;
            r_loop_pc    <= pc;
            r_loop_instr <= instr;
         end
      end
   end
   always_comb begin
      loop_found   = r_state == S_LOOP;
      timeout      = r_state == S_TIMEOUT;
      done         = loop_found || timeout;
      loop_period  = r_period;
      loop_pc      = r_loop_pc;
      loop_instr   = r_loop_instr;
      cycle_cnt    = r_cnt;
      hist_rd_data = r_hist[rd_idx];
   end
endmodule

// File: tb/tb_pc_loop_monitor.sv
// tb_pc_loop_monitor: directed self-checking bench for pc_loop_monitor
module tb_pc_loop_monitor;
   logic        clk = 1'b0;
   logic        rst, clr, valid;
   logic [31:0] pc, instr;
   logic [2:0]  rd_idx;
   logic [31:0] hist_rd_data, cycle_cnt, loop_pc, loop_instr;
   logic        loop_found, timeout, done;
   logic [3:0]  loop_period;
   int n_cmp = 0, n_err = 0;

   pc_loop_monitor dut (
      .clk(clk), .rst(rst), .clr(clr), .valid(valid), .pc(pc), .instr(instr),
      .rd_idx(rd_idx), .hist_rd_data(hist_rd_data), .cycle_cnt(cycle_cnt),
      .loop_found(loop_found), .loop_period(loop_period), .loop_pc(loop_pc),
      .loop_instr(loop_instr), .timeout(timeout), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        clr;
      logic        valid;
      logic [31:0] pc;
      logic [2:0]  rd_idx;
      logic [31:0] exp_cnt;
      logic [31:0] exp_hist;
      logic        exp_done;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, input logic [31:0] p);
      valid = v;
      pc    = p;
      instr = ~p;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1'b1, 32'h77);
      clr = 1'b0;
      valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; valid = 1'b0; pc = '0; instr = '0; rd_idx = '0;
      #2;
      chk("rst_cnt", cycle_cnt, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_loop", {31'b0, loop_found}, 0);
      chk("rst_hist", hist_rd_data, 0);
      #10 rst = 1'b0;

      // history shifting, valid gating, unwritten entries and clr
      vecs[0] = '{1'b0, 1'b1, 32'h10, 3'd0, 32'd1, 32'h10, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h20, 3'd1, 32'd2, 32'h10, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h99, 3'd0, 32'd2, 32'h20, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h30, 3'd2, 32'd3, 32'h10, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 32'h40, 3'd4, 32'd4, 32'h0,  1'b0};
      vecs[5] = '{1'b0, 1'b1, 32'h10, 3'd3, 32'd5, 32'h20, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 32'h10, 3'd7, 32'd5, 32'h0,  1'b0};
      vecs[7] = '{1'b1, 1'b1, 32'h50, 3'd0, 32'd0, 32'h0,  1'b0};
      for (int i = 0; i < 8; i++) begin
         clr    = vecs[i].clr;
         rd_idx = vecs[i].rd_idx;
         cyc(vecs[i].valid, vecs[i].pc);
         chk($sformatf("vec%0d_cnt", i), cycle_cnt, vecs[i].exp_cnt);
         chk($sformatf("vec%0d_hist", i), hist_rd_data, vecs[i].exp_hist);
         chk($sformatf("vec%0d_done", i), {31'b0, done}, {31'b0, vecs[i].exp_done});
      end
      clr = 1'b0; valid = 1'b0; rd_idx = '0;

      // self-loop
      repeat (16) cyc(1'b1, 32'h0040_0010);
      chk("self_pre_loop", {31'b0, loop_found}, 0);
      cyc(1'b1, 32'h0040_0010);
      chk("self_loop", {31'b0, loop_found}, 1);
      chk("self_period", {28'b0, loop_period}, 1);
      chk("self_pc", loop_pc, 32'h0040_0010);
      chk("self_instr", loop_instr, ~32'h0040_0010);
      chk("self_cnt", cycle_cnt, 17);
      chk("self_to", {31'b0, timeout}, 0);
      chk("self_done", {31'b0, done}, 1);
      cyc(1'b1, 32'h1234);
      chk("self_frozen_cnt", cycle_cnt, 17);
      chk("self_frozen_hist", hist_rd_data, 32'h0040_0010);
      do_clr();
      chk("clr_loop", {31'b0, loop_found}, 0);
      chk("clr_done", {31'b0, done}, 0);
      chk("clr_cnt", cycle_cnt, 0);
      chk("clr_period", {28'b0, loop_period}, 0);
      chk("clr_pc", loop_pc, 0);
      chk("clr_hist", hist_rd_data, 0);

      // period-3 loop: 19th retirement is pc 0x100
      for (int n = 0; n < 18; n++) cyc(1'b1, 32'h100 + 32'(4 * (n % 3)));
      chk("p3_pre_loop", {31'b0, loop_found}, 0);
      cyc(1'b1, 32'h100);
      chk("p3_loop", {31'b0, loop_found}, 1);
      chk("p3_period", {28'b0, loop_period}, 3);
      chk("p3_cnt", cycle_cnt, 19);
      chk("p3_pc", loop_pc, 32'h100);
      rd_idx = 3'd0; #1 chk("p3_hist0", hist_rd_data, 32'h100);
      rd_idx = 3'd1; #1 chk("p3_hist1", hist_rd_data, 32'h108);
      rd_idx = 3'd2; #1 chk("p3_hist2", hist_rd_data, 32'h104);
      rd_idx = 3'd0;
      do_clr();

      // valid gaps
      repeat (16) begin
         cyc(1'b1, 32'h0040_0010);
         cyc(1'b0, 32'h0040_0010);
      end
      chk("gap_pre_loop", {31'b0, loop_found}, 0);
      chk("gap_cnt", cycle_cnt, 16);
      cyc(1'b1, 32'h0040_0010);
      chk("gap_loop", {31'b0, loop_found}, 1);
      chk("gap_cnt_final", cycle_cnt, 17);
      do_clr();

      // near-loop broken: 15 X, Y, then 17 X before detection
      repeat (15) cyc(1'b1, 32'hA0);
      cyc(1'b1, 32'hB0);
      repeat (16) cyc(1'b1, 32'hA0);
      chk("near_no_loop", {31'b0, loop_found}, 0);
      chk("near_cnt", cycle_cnt, 32);
      cyc(1'b1, 32'hA0);
      chk("near_loop", {31'b0, loop_found}, 1);
      chk("near_period", {28'b0, loop_period}, 1);
      chk("near_cnt_final", cycle_cnt, 33);
      do_clr();

      // timeout
      for (int i = 0; i < 399; i++) cyc(1'b1, 32'(4 * i));
      chk("to_pre", {31'b0, timeout}, 0);
      chk("to_pre_cnt", cycle_cnt, 399);
      cyc(1'b1, 32'(4 * 399));
      chk("to_flag", {31'b0, timeout}, 1);
      chk("to_cnt", cycle_cnt, 400);
      chk("to_loop", {31'b0, loop_found}, 0);
      chk("to_done", {31'b0, done}, 1);
      repeat (3) cyc(1'b1, 32'h5555);
      chk("to_frozen_cnt", cycle_cnt, 400);
      chk("to_frozen_hist", hist_rd_data, 32'(4 * 399));
      do_clr();

      // loop completion on the budget's last retirement: loop wins
      for (int i = 0; i < 383; i++) cyc(1'b1, 32'(4 * i));
      repeat (17) cyc(1'b1, 32'hFFFF_0000);
      chk("both_loop", {31'b0, loop_found}, 1);
      chk("both_to", {31'b0, timeout}, 0);
      chk("both_cnt", cycle_cnt, 400);
      do_clr();

      // asynchronous reset mid-run
      for (int i = 0; i < 50; i++) cyc(1'b1, 32'(8 * i + 4));
      chk("arst_pre_cnt", cycle_cnt, 50);
      rst = 1'b1;
      #1;
      chk("arst_cnt", cycle_cnt, 0);
      chk("arst_hist", hist_rd_data, 0);
      chk("arst_done", {31'b0, done}, 0);
      rst = 1'b0;
      valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
